// File: rtl/delay_arbiter_if.sv
// Bus between the delay requesters and delay_arbiter: timebase strobe, levels, per-requester
// tick counts going in, and the grant/done/busy/owner status coming back.
interface delay_arbiter_if #(
   parameter int NREQ = 4,
   parameter int N    = 8
);
   localparam int OW = $clog2(NREQ);

   logic              ena;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] ticks;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [OW-1:0]     owner;

   modport master (
      output ena, req, ticks,
      input  grant, done, busy, owner
   );

   modport slave (
      input  ena, req, ticks,
      output grant, done, busy, owner
   );
endinterface

// File: rtl/delay_arbiter.sv
// Round-robin arbiter lending one shared tick counter to NREQ one-shot delay requesters.
// Macro DELAY_ARBITER_ABORT_EN: owner dropping req while counting aborts its delay (no done).
module delay_arbiter #(
   parameter int NREQ = 4,
   parameter int N    = 8
) (
   input logic            clk,
   input logic            rst,
   delay_arbiter_if.slave bus
);
   localparam int OW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [OW-1:0]   owner_reg, owner_next;
   logic [OW-1:0]   ptr_reg, ptr_next;
   logic [N-1:0]    tick_cap_reg, tick_cap_next;
   logic [N-1:0]    count_reg, count_next;
   logic [NREQ-1:0] grant_reg, grant_next;
   logic [NREQ-1:0] done_reg, done_next;
   logic            busy_reg, busy_next;

   logic [NREQ-1:0] owner_onehot;
   logic [OW-1:0]   pick;
   logic            pick_valid;
   logic [OW-1:0]   ptr_after;

   assign ptr_after = OW'((int'(owner_reg) + 1) % NREQ);

   // First requester at or above the pointer, wrapping; the pointer slot has top priority.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!pick_valid && bus.req[(int'(ptr_reg) + k) % NREQ]) begin
            pick       = OW'((int'(ptr_reg) + k) % NREQ);
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      ptr_next      = ptr_reg;
      tick_cap_next = tick_cap_reg;
      count_next    = count_reg;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               state_next    = COUNT;
               owner_next    = pick;
               tick_cap_next = bus.ticks[int'(pick)*N +: N];
               count_next    = '0;
            end
         end
         COUNT: begin
`ifdef DELAY_ARBITER_ABORT_EN
            if (!bus.req[owner_reg]) begin
               state_next = IDLE;
               ptr_next   = ptr_after;
            end else
`endif
            // Compare before increment so an all-ones delay never wraps.
            if (bus.ena) begin
               if (count_reg == tick_cap_reg) begin
                  state_next = DONE;
               end else begin
                  count_next = count_reg + N'(1);
               end
            end
         end
         DONE: begin
            state_next = IDLE;
            ptr_next   = ptr_after;
         end
         default: state_next = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign owner_onehot[gi] = (owner_next == OW'(gi));
   end

   // Outputs are decoded from the next state so they can be registered alongside it.
   always_comb begin
      grant_next = (state_next == COUNT) ? owner_onehot : '0;
      done_next  = (state_next == DONE)  ? owner_onehot : '0;
      busy_next  = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         owner_reg    <= '0;
         ptr_reg      <= '0;
         tick_cap_reg <= '0;
         count_reg    <= '0;
         grant_reg    <= '0;
         done_reg     <= '0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         ptr_reg      <= ptr_next;
         tick_cap_reg <= tick_cap_next;
         count_reg    <= count_next;
         grant_reg    <= grant_next;
         done_reg     <= done_next;
         busy_reg     <= busy_next;
      end
   end

   assign bus.grant = grant_reg;
   assign bus.done  = done_reg;
   assign bus.busy  = busy_reg;
   assign bus.owner = owner_reg;
endmodule

// File: tb/tb_delay_arbiter.sv
// Self-checking bench for delay_arbiter: directed scenarios plus randomized traffic
// compared against a remaining-ticks reference model.
module tb_delay_arbiter;
   localparam int NREQ = 4;
   localparam int N    = 8;
   localparam int OW   = $clog2(NREQ);

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   delay_arbiter_if #(.NREQ(NREQ), .N(N)) bus ();
   delay_arbiter #(.NREQ(NREQ), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b0;
      bus.req   = '0;
      bus.ena   = 1'b0;
      bus.ticks = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // One isolated delay for requester 'who'; ena high on every div-th cycle.
   task automatic run_one(input int who, input int t, input int div, input string tag);
      int g_cycles, e_cycles, cyc;
      bit seen_done;
      g_cycles  = 0;
      e_cycles  = 0;
      cyc       = 0;
      seen_done = 0;
      bus.ticks[who*N +: N] = N'(t);
      bus.req = NREQ'(1) << who;
      bus.ena = 1'b1;
      while (!seen_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (bus.done != '0) begin
            seen_done = 1;
            check({tag, "_done"}, 32'(bus.done), 32'(NREQ'(1) << who));
            check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
            bus.req = '0;
         end else begin
            if (bus.grant != '0) begin
               check({tag, "_grant"}, 32'(bus.grant), 32'(NREQ'(1) << who));
               g_cycles++;
               bus.ticks = $urandom;
            end
            bus.ena = ((cyc % div) == 0);
            if (bus.grant != '0 && bus.ena) e_cycles++;
         end
      end
      check({tag, "_finished"}, 32'(seen_done), 32'd1);
      check({tag, "_en_ticks"}, 32'(e_cycles), 32'(t + 1));
      if (div == 1) check({tag, "_grant_cycles"}, 32'(g_cycles), 32'(t + 1));
      else check({tag, "_held"}, 32'(g_cycles >= div * t + 1), 32'd1);
      @(negedge clk);
      check({tag, "_after"}, {bus.done, bus.busy, bus.grant}, 32'd0);
   endtask

   // Reference model: free / counting (with enabled ticks still owed) / done.
   int m_phase, m_owner, m_left, m_ptr;

   task automatic model_edge();
      bit found;
      int j;
      found = 0;
      case (m_phase)
         0: begin
            for (int k = 0; k < NREQ; k++) begin
               j = (m_ptr + k) % NREQ;
               if (!found && bus.req[j]) begin
                  found   = 1;
                  m_owner = j;
                  m_left  = int'(bus.ticks[j*N +: N]) + 1;
                  m_phase = 1;
               end
            end
         end
         1: begin
`ifdef DELAY_ARBITER_ABORT_EN
            if (!bus.req[m_owner]) begin
               m_phase = 0;
               m_ptr   = (m_owner + 1) % NREQ;
            end else
`endif
            if (bus.ena) begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
         end
         default: begin
            m_phase = 0;
            m_ptr   = (m_owner + 1) % NREQ;
         end
      endcase
   endtask

   initial begin
      int cyc, cnt, n_grants;
      bit seen, done_since;
      logic [NREQ-1:0] prev, exp_g, exp_d;

      bus.req   = '0;
      bus.ena   = 1'b0;
      bus.ticks = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("reset_idle", {bus.grant, bus.done, bus.busy, bus.owner}, 32'd0);
      end

      run_one(1, 3, 1, "single");
      run_one(0, 2, 3, "gated");
      run_one(2, 255, 1, "max_ticks");

      // Asynchronous reset in the middle of a delay.
      bus.ena = 1'b1;
      bus.ticks[3*N +: N] = N'(20);
      bus.req = 4'b1000;
      repeat (5) @(negedge clk);
      check("midcount_granted", 32'(bus.grant), 32'h8);
      #2 rst = 1'b0;
      #1 check("midcount_async_clear", {bus.grant, bus.busy}, 32'd0);
      bus.req = '0;
      @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done != '0) seen = 1;
      end
      check("midcount_no_done", 32'(seen), 32'd0);

      // Round-robin with every requester held and zero-tick delays.
      do_reset();
      bus.ena    = 1'b1;
      bus.req    = '1;
      n_grants   = 0;
      done_since = 1;
      prev       = '0;
      cyc        = 0;
      while (n_grants < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.done != '0) done_since = 1;
         if (bus.grant != '0 && prev == '0) begin
            check("rr_order", 32'(bus.grant), 32'(NREQ'(1) << (n_grants % NREQ)));
            check("rr_done_first", 32'(done_since), 32'd1);
            done_since = 0;
            n_grants++;
         end
         prev = bus.grant;
      end
      check("rr_count", 32'(n_grants), 32'd5);
      bus.req = '0;

      // Owner drops req three cycles into a 10-tick delay while requester 1 waits.
      do_reset();
      bus.ena = 1'b1;
      bus.ticks[0 +: N] = N'(10);
      bus.req = 4'b0001;
      cnt = 0;
      cyc = 0;
      while (cnt < 3 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (bus.grant == 4'b0001) cnt++;
      end
      bus.req = 4'b0010;
`ifdef DELAY_ARBITER_ABORT_EN
      @(negedge clk);
      check("abort_idle", {bus.grant, bus.done, bus.busy}, 32'd0);
      @(negedge clk);
      check("abort_regrant", 32'(bus.grant), 32'h2);
      check("abort_owner", 32'(bus.owner), 32'd1);
`else
      seen = 0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.grant == 4'b0001) cnt++;
         if (bus.done != '0) begin
            seen = 1;
            check("noabort_done", 32'(bus.done), 32'h1);
         end
      end
      check("noabort_seen", 32'(seen), 32'd1);
      check("noabort_cycles", 32'(cnt), 32'd11);
      repeat (2) @(negedge clk);
      check("noabort_next", 32'(bus.grant), 32'h2);
`endif
      bus.req = '0;

      // Randomized traffic against the reference model.
      do_reset();
      m_phase = 0;
      m_owner = 0;
      m_left  = 0;
      m_ptr   = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         exp_g = (m_phase == 1) ? (NREQ'(1) << m_owner) : '0;
         exp_d = (m_phase == 2) ? (NREQ'(1) << m_owner) : '0;
         check("random", {bus.grant, bus.done, bus.busy, bus.owner},
               {exp_g, exp_d, (m_phase != 0), OW'(m_owner)});
         bus.ena = ($urandom_range(3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            bus.ticks[i*N +: N] = N'($urandom_range(5));
            if (!bus.req[i]) bus.req[i] = ($urandom_range(2) == 0);
            else if (bus.done[i]) bus.req[i] = ($urandom_range(1) == 0);
`ifdef DELAY_ARBITER_ABORT_EN
            if (bus.grant[i] && $urandom_range(15) == 0) bus.req[i] = 1'b0;
`endif
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
